joypad_port: RTL

//  NES-style controller port serving CPU reads of $4016/$4017 and strobe writes to $4016.

---
 rtl/joypad_port_if.sv | 11 +
 rtl/joypad_port.sv | 90 +++++++++
 2 files changed

// File: rtl/joypad_port_if.sv
// CPU-side register bus of the controller port: $4016 strobe write, $4016/$4017 reads, read data.
interface joypad_port_if;
    logic       addr4016w;
    logic [7:0] cpu_data;
    logic       naddr4016r;
    logic       naddr4017r;
    logic [7:0] data_out;

    modport master (output addr4016w, cpu_data, naddr4016r, naddr4017r, input data_out);
    modport slave  (input addr4016w, cpu_data, naddr4016r, naddr4017r, output data_out);
endinterface

// File: rtl/joypad_port.sv
// NES controller port: 2-flop sync + per-bit debounce of two pads, latch/shift serialiser for $4016/$4017.
// data_out updates the cycle after a read falling edge and holds; no backpressure, the CPU is never stalled.
module joypad_port #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic [7:0]        pad0_raw,
    input  logic [7:0]        pad1_raw,
    joypad_port_if.slave      bus,
    output logic [15:0]       pad_state
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [15:0]   sync1;
    logic [15:0]   sync2;
    logic [15:0]   stable;
    logic [CW-1:0] cnt [16];
    logic          strobe;
    logic [7:0]    shift0;
    logic [7:0]    shift1;
    logic          hist0;
    logic          hist1;
    logic [7:0]    data_q;
    logic          rd0;
    logic          rd1;
    logic          unused_cpu_data;

    assign unused_cpu_data = ^bus.cpu_data[7:1];

    // A read is the falling edge of the select, so a long-held select counts once.
    assign rd0 = ~bus.naddr4016r & hist0;
    assign rd1 = ~bus.naddr4017r & hist1;

    assign pad_state    = ~stable;
    assign bus.data_out = data_q;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            sync1  <= 16'hFFFF;
            sync2  <= 16'hFFFF;
            stable <= 16'hFFFF;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
            strobe <= 1'b0;
            shift0 <= 8'h00;
            shift1 <= 8'h00;
            hist0  <= 1'b1;
            hist1  <= 1'b1;
            data_q <= 8'h40;
        end else begin
            sync1 <= {pad1_raw, pad0_raw};
            sync2 <= sync1;

            for (int i = 0; i < 16; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end

            hist0 <= bus.naddr4016r;
            hist1 <= bus.naddr4017r;

            if (bus.addr4016w) begin
                strobe <= bus.cpu_data[0];
            end

            // Reload/shift look at the pre-edge strobe, so a coincident write only takes effect next cycle.
            if (strobe) begin
                shift0 <= pad_state[7:0];
                shift1 <= pad_state[15:8];
            end else begin
                if (rd0) shift0 <= {1'b1, shift0[7:1]};
                if (rd1) shift1 <= {1'b1, shift1[7:1]};
            end

            if (rd0) begin
                data_q <= {7'b0100_000, shift0[0]};
            end else if (rd1) begin
                data_q <= {7'b0100_000, shift1[0]};
            end
        end
    end
endmodule
